// File: rtl/mem_pkg.sv
// Shared definitions for the load/store unit: funct3 size codes, the
// legality check for a request, and the access state encoding.
package mem_pkg;

  localparam int unsigned XLEN = 32;

  // Load funct3 codes
  localparam logic [2:0] CODE_LB  = 3'b000;
  localparam logic [2:0] CODE_LH  = 3'b001;
  localparam logic [2:0] CODE_LW  = 3'b010;
  localparam logic [2:0] CODE_LBU = 3'b100;
  localparam logic [2:0] CODE_LHU = 3'b101;

  // Store funct3 codes
  localparam logic [2:0] CODE_SB  = 3'b000;
  localparam logic [2:0] CODE_SH  = 3'b001;
  localparam logic [2:0] CODE_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    RESP  = 2'd3
  } lsu_state_e;

  // 1 when the funct3 code has no meaning for the given direction
  function automatic logic code_illegal(input logic we, input logic [2:0] code);
    if (we) begin
      return code > CODE_SW;
    end
    return (code == 3'b011) || (code[2:1] == 2'b11);
  endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Combinational lane logic for one access.
//   code/offset/wdata : request funct3, addr[1:0], right-aligned store data
//   rbuf              : 64-bit read buffer {high word, low word}
//   span              : access crosses into the next word
//   mask              : 8-bit byte mask over both beats
//   wdata0/wdata1     : lane-shifted store data for beat 0 / beat 1
//   rdata             : extracted and extended load result
module mem_lsu_align
  import mem_pkg::*;
(
  input  logic [2:0]  code,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [63:0] rbuf,
  output logic        span,
  output logic [7:0]  mask,
  output logic [31:0] wdata0,
  output logic [31:0] wdata1,
  output logic [31:0] rdata
);

  logic [2:0]  size;
  logic [3:0]  size_mask;
  logic [5:0]  bit_off;
  logic [31:0] rshift;

  // Access size in bytes and its right-aligned byte mask
  always_comb begin
    size      = 3'd4;
    size_mask = 4'b1111;
    case (code[1:0])
      2'b00: begin size = 3'd1; size_mask = 4'b0001; end
      2'b01: begin size = 3'd2; size_mask = 4'b0011; end
      default: begin size = 3'd4; size_mask = 4'b1111; end
    endcase
  end

  assign bit_off = {1'b0, offset, 3'b000};
  assign span    = (3'({1'b0, offset}) + size) > 3'd4;
  assign mask    = 8'({4'b0000, size_mask} << offset);
  assign wdata0  = wdata << bit_off;
  // Offset 0 shifts by 32 and yields 0; no second beat exists in that case
  assign wdata1  = wdata >> (6'd32 - bit_off);
  assign rshift  = 32'(rbuf >> bit_off);

  // Load extract and sign/zero extension
  always_comb begin
    rdata = 32'h0;
    case (code)
      CODE_LB:  rdata = {{24{rshift[7]}}, rshift[7:0]};
      CODE_LH:  rdata = {{16{rshift[15]}}, rshift[15:0]};
      CODE_LW:  rdata = rshift;
      CODE_LBU: rdata = {24'h0, rshift[7:0]};
      CODE_LHU: rdata = {16'h0, rshift[15:0]};
      default:  rdata = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Load/store initiator: turns one core load/store into one or two
// word-aligned bus beats with byte strobes and returns the extended result.
//   clk, rst                 : clock, async active-high reset
//   lsu_req/we/code/addr/wdata : core request (sampled while not busy)
//   lsu_busy/done/err/rdata  : core-side status and load result
//   mem_req/we/addr/wstrb/wdata : bus request, held until mem_ack
//   mem_ack/mem_rdata        : bus beat completion and read word
module mem_lsu
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lsu_req,
  input  logic        lsu_we,
  input  logic [2:0]  lsu_code,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_busy,
  output logic        lsu_done,
  output logic        lsu_err,
  output logic [31:0] lsu_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam logic [CNT_W:0] TO_LIMIT = (CNT_W+1)'(TIMEOUT_CYC);

  lsu_state_e       state;
  logic             we_q;
  logic [2:0]       code_q;
  logic [1:0]       offset_q;
  logic [31:0]      wdata_q;
  logic [31:0]      buf_lo;
  logic [CNT_W-1:0] cnt;

  logic [2:0]  a_code;
  logic [1:0]  a_offset;
  logic [31:0] a_wdata;
  logic [63:0] a_rbuf;
  logic        a_span;
  logic [7:0]  a_mask;
  logic [31:0] a_wdata0;
  logic [31:0] a_wdata1;
  logic [31:0] a_rdata;
  logic        timeout_hit;

  // In IDLE the lane logic sees the incoming request so beat 0 can be
  // launched on the accept edge; afterwards it sees the latched request.
  // The final-beat read word is fed straight in so the result is ready in RESP.
  always_comb begin
    if (state == IDLE) begin
      a_code   = lsu_code;
      a_offset = lsu_addr[1:0];
      a_wdata  = lsu_wdata;
    end else begin
      a_code   = code_q;
      a_offset = offset_q;
      a_wdata  = wdata_q;
    end
    a_rbuf = (state == BEAT1) ? {mem_rdata, buf_lo} : {32'h0, mem_rdata};
  end

  // Fires on the last waiting cycle so mem_req is high for TIMEOUT_CYC cycles
  assign timeout_hit = (TIMEOUT_CYC != 0) &&
                       (({1'b0, cnt} + (CNT_W+1)'(1)) == TO_LIMIT);

  mem_lsu_align u_align (
    .code   (a_code),
    .offset (a_offset),
    .wdata  (a_wdata),
    .rbuf   (a_rbuf),
    .span   (a_span),
    .mask   (a_mask),
    .wdata0 (a_wdata0),
    .wdata1 (a_wdata1),
    .rdata  (a_rdata)
  );

  // Access FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      we_q      <= 1'b0;
      code_q    <= 3'b000;
      offset_q  <= 2'b00;
      wdata_q   <= 32'h0;
      buf_lo    <= 32'h0;
      cnt       <= '0;
      lsu_busy  <= 1'b0;
      lsu_done  <= 1'b0;
      lsu_err   <= 1'b0;
      lsu_rdata <= 32'h0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wstrb <= 4'b0000;
      mem_wdata <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (lsu_req) begin
            we_q      <= lsu_we;
            code_q    <= lsu_code;
            offset_q  <= lsu_addr[1:0];
            wdata_q   <= lsu_wdata;
            lsu_busy  <= 1'b1;
            lsu_rdata <= 32'h0;
            if (code_illegal(lsu_we, lsu_code)) begin
              state    <= RESP;
              lsu_done <= 1'b1;
              lsu_err  <= 1'b1;
            end else begin
              state     <= BEAT0;
              mem_req   <= 1'b1;
              mem_we    <= lsu_we;
              mem_addr  <= {lsu_addr[31:2], 2'b00};
              mem_wstrb <= a_mask[3:0];
              mem_wdata <= a_wdata0;
            end
          end
        end

        BEAT0, BEAT1: begin
          if (mem_ack) begin
            cnt <= '0;
            if (state == BEAT0) begin
              buf_lo <= mem_rdata;
            end
            if ((state == BEAT0) && a_span) begin
              // mem_req stays high straight into the second beat
              state     <= BEAT1;
              mem_addr  <= mem_addr + 32'd4;
              mem_wstrb <= a_mask[7:4];
              mem_wdata <= a_wdata1;
            end else begin
              state    <= RESP;
              mem_req  <= 1'b0;
              lsu_done <= 1'b1;
              lsu_err  <= 1'b0;
              if (!we_q) begin
                lsu_rdata <= a_rdata;
              end
            end
          end else if (timeout_hit) begin
            state    <= RESP;
            cnt      <= '0;
            mem_req  <= 1'b0;
            lsu_done <= 1'b1;
            lsu_err  <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        RESP: begin
          state    <= IDLE;
          lsu_done <= 1'b0;
          lsu_err  <= 1'b0;
          lsu_busy <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Randomised self-checking bench for mem_lsu against a byte-level model.
module tb_mem_lsu;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_req;
  logic        lsu_we;
  logic [2:0]  lsu_code;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic        lsu_busy;
  logic        lsu_done;
  logic        lsu_err;
  logic [31:0] lsu_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ack   = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Responder controls (written by the stimulus only)
  int unsigned max_wait   = 0;
  bit          no_ack     = 1'b0;
  bit          stall_arm  = 1'b0;
  // Responder state (written by the responder only)
  bit          stalled    = 1'b0;
  bit          in_beat    = 1'b0;
  int unsigned wait_left  = 0;
  int unsigned waits_total = 0;
  logic [31:0] beat_addr_q[$];
  logic [3:0]  beat_strb_q[$];
  logic        beat_we_q[$];
  logic [31:0] beat_wdata_q[$];

  logic [7:0] bus_mem [int unsigned];
  logic [7:0] ref_mem [int unsigned];

  always #5 clk = ~clk;

  mem_lsu #(.TIMEOUT_CYC(TO), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .lsu_req   (lsu_req),
    .lsu_we    (lsu_we),
    .lsu_code  (lsu_code),
    .lsu_addr  (lsu_addr),
    .lsu_wdata (lsu_wdata),
    .lsu_busy  (lsu_busy),
    .lsu_done  (lsu_done),
    .lsu_err   (lsu_err),
    .lsu_rdata (lsu_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wstrb (mem_wstrb),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] def_byte(input logic [31:0] a);
    return 8'(a * 32'd37 + 32'd11) ^ a[15:8];
  endfunction

  function automatic logic [7:0] bus_byte(input logic [31:0] a);
    if (bus_mem.exists(a)) return bus_mem[a];
    return def_byte(a);
  endfunction

  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return def_byte(a);
  endfunction

  function automatic logic [31:0] lanes(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  task automatic set_word(input logic [31:0] a, input logic [31:0] w);
    for (int j = 0; j < 4; j++) begin
      bus_mem[a + 32'(j)] = w[8*j +: 8];
      ref_mem[a + 32'(j)] = w[8*j +: 8];
    end
  endtask

  // Bus slave: random wait states per beat, decided on the falling edge
  always @(negedge clk) begin
    if (rst) begin
      mem_ack = 1'b0;
      stalled = 1'b0;
      in_beat = 1'b0;
    end else if (!mem_req) begin
      mem_ack = 1'b0;
      in_beat = 1'b0;
    end else begin
      if (!in_beat) begin
        in_beat   = 1'b1;
        wait_left = $urandom_range(max_wait, 0);
      end
      if (no_ack || stalled || wait_left > 0) begin
        mem_ack = 1'b0;
        waits_total++;
        if (wait_left > 0) wait_left--;
      end else begin
        mem_ack = 1'b1;
        for (int j = 0; j < 4; j++) mem_rdata[8*j +: 8] = bus_byte(mem_addr + 32'(j));
        beat_addr_q.push_back(mem_addr);
        beat_strb_q.push_back(mem_wstrb);
        beat_we_q.push_back(mem_we);
        beat_wdata_q.push_back(mem_wdata);
        if (mem_we) begin
          for (int j = 0; j < 4; j++)
            if (mem_wstrb[j]) bus_mem[mem_addr + 32'(j)] = mem_wdata[8*j +: 8];
        end
        in_beat = 1'b0;
        if (stall_arm) stalled = 1'b1;
      end
    end
  end

  // One complete access, checked against the byte-level model
  task automatic run_access(input logic we, input logic [2:0] code, input logic [31:0] addr,
                            input logic [31:0] wdata, input int unsigned mw, input bit tmo,
                            output logic [31:0] rd);
    logic        legal;
    int unsigned size, nb, lat, w0, b0, k, lane;
    logic [31:0] first, b, raw, exp_rd;
    logic [3:0]  es [2];
    logic [31:0] ew [2];
    logic [31:0] ea [2];

    legal = we ? (code <= 3'b010) : (code inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    size  = (code[1:0] == 2'b00) ? 1 : (code[1:0] == 2'b01) ? 2 : 4;
    first = {addr[31:2], 2'b00};
    ea[0] = first;
    ea[1] = first + 32'd4;
    es[0] = 4'b0; es[1] = 4'b0;
    ew[0] = 32'h0; ew[1] = 32'h0;
    nb    = 1;
    raw   = 32'h0;
    for (int i = 0; i < int'(size); i++) begin
      b    = addr + 32'(i);
      k    = ({b[31:2], 2'b00} == first) ? 0 : 1;
      lane = int'(b[1:0]);
      if (k == 1) nb = 2;
      es[k][lane] = 1'b1;
      ew[k][8*lane +: 8] = wdata[8*i +: 8];
      raw[8*i +: 8] = ref_byte(b);
    end
    case (code)
      3'b000:  exp_rd = {{24{raw[7]}}, raw[7:0]};
      3'b001:  exp_rd = {{16{raw[15]}}, raw[15:0]};
      3'b100:  exp_rd = {24'h0, raw[7:0]};
      3'b101:  exp_rd = {16'h0, raw[15:0]};
      default: exp_rd = raw;
    endcase
    if (!legal || tmo) begin
      nb     = 0;
      exp_rd = 32'h0;
    end

    max_wait = mw;
    no_ack   = tmo;
    w0 = waits_total;
    b0 = beat_addr_q.size();

    @(negedge clk);
    chk("idle_not_busy", 32'(lsu_busy), 32'd0);
    lsu_req   = 1'b1;
    lsu_we    = we;
    lsu_code  = code;
    lsu_addr  = addr;
    lsu_wdata = wdata;
    @(negedge clk);
    lsu_req   = 1'b0;
    lsu_we    = 1'($urandom);
    lsu_code  = 3'($urandom);
    lsu_addr  = $urandom;
    lsu_wdata = $urandom;
    chk("busy_after_accept", 32'(lsu_busy), 32'd1);
    lat = 1;
    while (!lsu_done && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    chk("done_seen", 32'(lsu_done), 32'd1);
    chk("err", 32'(lsu_err), 32'(!legal || tmo));
    chk("latency", 32'(lat), legal ? 32'(1 + nb + (waits_total - w0)) : 32'd1);
    chk("req_low_at_done", 32'(mem_req), 32'd0);
    if (tmo) chk("timeout_req_cycles", 32'(waits_total - w0), 32'(TO));
    if (!we || !legal) chk("rdata", lsu_rdata, exp_rd);
    chk("beat_count", 32'(beat_addr_q.size() - b0), 32'(nb));
    if (beat_addr_q.size() == b0 + nb) begin
      for (int i = 0; i < int'(nb); i++) begin
        chk("beat_addr", beat_addr_q[b0+i], ea[i]);
        chk("beat_strb", 32'(beat_strb_q[b0+i]), 32'(es[i]));
        chk("beat_we", 32'(beat_we_q[b0+i]), 32'(we));
        if (we) chk("beat_wdata", beat_wdata_q[b0+i] & lanes(es[i]), ew[i]);
      end
    end
    if (we && legal && !tmo) begin
      for (int i = 0; i < int'(size); i++) ref_mem[addr + 32'(i)] = wdata[8*i +: 8];
    end
    rd = lsu_rdata;
    no_ack = 1'b0;
    @(negedge clk);
    chk("done_one_pulse", 32'(lsu_done), 32'd0);
    chk("busy_cleared", 32'(lsu_busy), 32'd0);
    chk("rdata_held", lsu_rdata, rd);
  endtask

  initial begin
    logic [31:0] rd, a, wd;
    logic [2:0]  c;
    logic        w;
    int unsigned b0, n;

    rst = 1'b1;
    lsu_req = 1'b0; lsu_we = 1'b0; lsu_code = 3'b000; lsu_addr = 32'h0; lsu_wdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_busy", 32'(lsu_busy), 32'd0);
    chk("rst_done", 32'(lsu_done), 32'd0);
    chk("rst_err", 32'(lsu_err), 32'd0);
    chk("rst_rdata", lsu_rdata, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wstrb", 32'(mem_wstrb), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Aligned word load, zero wait
    set_word(32'h10, 32'h11223344);
    run_access(1'b0, 3'b010, 32'h10, 32'h0, 0, 1'b0, rd);
    chk("lw_aligned_val", rd, 32'h11223344);

    // Byte loads of 0x80 with sign and zero extension
    set_word(32'h10, 32'h80223344);
    run_access(1'b0, 3'b000, 32'h13, 32'h0, 0, 1'b0, rd);
    chk("lb_val", rd, 32'hFFFFFF80);
    run_access(1'b0, 3'b100, 32'h13, 32'h0, 0, 1'b0, rd);
    chk("lbu_val", rd, 32'h00000080);

    // Misaligned word load spanning two words
    set_word(32'h0C, 32'h44332211);
    set_word(32'h10, 32'h88776655);
    run_access(1'b0, 3'b010, 32'h0E, 32'h0, 0, 1'b0, rd);
    chk("lw_span_val", rd, 32'h66554433);

    // Misaligned word store: exact lane-shifted data on both beats
    b0 = beat_addr_q.size();
    run_access(1'b1, 3'b010, 32'h06, 32'hAABBCCDD, 0, 1'b0, rd);
    if (beat_wdata_q.size() >= b0 + 2) begin
      chk("sw_b0_wdata", beat_wdata_q[b0], 32'hCCDD0000);
      chk("sw_b1_wdata", beat_wdata_q[b0+1], 32'h0000AABB);
    end else begin
      chk("sw_beats_present", 32'(beat_wdata_q.size() - b0), 32'd2);
    end

    // Timeout with the slave never acknowledging
    run_access(1'b0, 3'b010, 32'h20, 32'h0, 0, 1'b1, rd);

    // Illegal codes: no bus traffic, error response
    run_access(1'b0, 3'b011, 32'h20, 32'h0, 0, 1'b0, rd);
    run_access(1'b1, 3'b101, 32'h24, 32'h12345678, 0, 1'b0, rd);

    // Word load wrapping past the top of the address space
    run_access(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, 1, 1'b0, rd);

    // Reset while the second beat is outstanding
    max_wait  = 0;
    stall_arm = 1'b1;
    @(negedge clk);
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_code = 3'b010; lsu_addr = 32'h0E;
    @(negedge clk);
    lsu_req = 1'b0;
    @(posedge clk);
    #2;
    chk("beat1_req_before_rst", 32'(mem_req), 32'd1);
    chk("beat1_addr_before_rst", mem_addr, 32'h10);
    rst = 1'b1;
    #1;
    chk("rst_async_req_drop", 32'(mem_req), 32'd0);
    chk("rst_async_busy", 32'(lsu_busy), 32'd0);
    stall_arm = 1'b0;
    n = 0;
    repeat (3) begin
      @(negedge clk);
      if (lsu_done) n++;
    end
    chk("rst_no_done", 32'(n), 32'd0);
    rst = 1'b0;
    run_access(1'b0, 3'b001, 32'h11, 32'h0, 0, 1'b0, rd);

    // Randomised mix of loads and stores
    for (int t = 0; t < 200; t++) begin
      w = 1'($urandom);
      if ($urandom_range(9, 0) == 0) a = 32'hFFFFFFFC + 32'($urandom_range(3, 0));
      else a = 32'($urandom_range(63, 0));
      if (w) c = ($urandom_range(7, 0) == 0) ? 3'($urandom_range(7, 3)) : 3'($urandom_range(2, 0));
      else c = 3'($urandom_range(7, 0));
      wd = $urandom;
      run_access(w, c, a, wd, $urandom_range(2, 0), 1'b0, rd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
